alu_share_arb: RTL and testbench

Two-requester arbiter and one-entry response buffer wrapped around a single `alu` instance, WIDTH-bit datapath. It lets the core execute stage (requester 0) and the debug/test port (requester 1) share one ALU. Sharing is round-robin with an optional lock for atomic multi-operation sequences. Each accepted operation yields exactly one registered response, tagged with its requester id, on a valid/ready channel.

---
 rtl/alu_share_arb.sv | 210 +++++++++++++++++++++
 tb/tb_alu_share_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter with optional lock, sharing one ALU,
// followed by a one-entry registered response buffer (valid/ready).

// Single-cycle integer ALU: R/I arithmetic, branches, JAL/JALR, LUI/AUIPC.
// rs2 doubles as the immediate for non-R-type operations.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] jump_target,
  output logic             zero,
  output logic             branch_taken
);
  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] shamt;
  logic          alt;

  assign shamt = rs2[SW-1:0];
  assign alt   = (func7 == 7'b0100000);

  // Result, target and flags are purely combinational from the operands.
  always_comb begin
    alu_result   = '0;
    jump_target  = pc + rs2;
    branch_taken = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011: begin
        case (func3)
          3'b000: alu_result = (opcode == 7'b0110011 && alt) ? rs1 - rs2 : rs1 + rs2;
          3'b001: alu_result = rs1 << shamt;
          3'b010: alu_result = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
          3'b011: alu_result = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
          3'b100: alu_result = rs1 ^ rs2;
          3'b101: begin
            if (alt) alu_result = $signed(rs1) >>> shamt;
            else     alu_result = rs1 >> shamt;
          end
          3'b110: alu_result = rs1 | rs2;
          default: alu_result = rs1 & rs2;
        endcase
      end
      7'b1100011: begin
        alu_result = rs1 - rs2;
        case (func3)
          3'b000: branch_taken = (rs1 == rs2);
          3'b001: branch_taken = (rs1 != rs2);
          3'b100: branch_taken = ($signed(rs1) < $signed(rs2));
          3'b101: branch_taken = ($signed(rs1) >= $signed(rs2));
          3'b110: branch_taken = (rs1 < rs2);
          3'b111: branch_taken = (rs1 >= rs2);
          default: branch_taken = 1'b0;
        endcase
      end
      7'b1101111: alu_result = pc + WIDTH'(4);
      7'b1100111: begin
        alu_result  = pc + WIDTH'(4);
        jump_target = (rs1 + rs2) & {{(WIDTH-1){1'b1}}, 1'b0};
      end
      7'b0110111: alu_result = rs2;
      7'b0010111: alu_result = pc + rs2;
      default:    alu_result = '0;
    endcase
    zero = (alu_result == '0);
  end
endmodule

module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_lock,
  input  logic [13:0]        req_opcode,
  input  logic [5:0]         req_func3,
  input  logic [13:0]        req_func7,
  input  logic [2*WIDTH-1:0] req_rs1,
  input  logic [2*WIDTH-1:0] req_rs2,
  input  logic [2*WIDTH-1:0] req_pc,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [WIDTH-1:0]   resp_result,
  output logic [WIDTH-1:0]   resp_jump_target,
  output logic               resp_zero,
  output logic               resp_branch_taken,
  output logic               locked,
  output logic               lock_owner
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t state, state_next;
  logic       last_grant;
  logic [1:0] grant;
  logic       gid;
  logic       can_load;
  logic       accept;

  logic [6:0]       op_arr  [2];
  logic [2:0]       f3_arr  [2];
  logic [6:0]       f7_arr  [2];
  logic [WIDTH-1:0] rs1_arr [2];
  logic [WIDTH-1:0] rs2_arr [2];
  logic [WIDTH-1:0] pc_arr  [2];

  logic [WIDTH-1:0] alu_result, jump_target;
  logic             alu_zero, alu_branch_taken;

  // Unpack the per-requester operation fields.
  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign op_arr[gi]  = req_opcode[7*gi +: 7];
    assign f3_arr[gi]  = req_func3[3*gi +: 3];
    assign f7_arr[gi]  = req_func7[7*gi +: 7];
    assign rs1_arr[gi] = req_rs1[WIDTH*gi +: WIDTH];
    assign rs2_arr[gi] = req_rs2[WIDTH*gi +: WIDTH];
    assign pc_arr[gi]  = req_pc[WIDTH*gi +: WIDTH];
  end

  // Grant: lock owner only while locked, otherwise round-robin on contest.
  always_comb begin
    grant = 2'b00;
    if (locked) begin
      if (lock_owner) grant = {req_valid[1], 1'b0};
      else            grant = {1'b0, req_valid[0]};
    end else if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

  // With no grant gid is 0, so the mux defaults to requester 0.
  assign gid       = grant[1];
  assign can_load  = !resp_valid || resp_ready;
  assign req_ready = rst ? 2'b00 : (grant & {2{can_load}});
  assign accept    = |req_ready;

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode       (op_arr[gid]),
    .func3        (f3_arr[gid]),
    .func7        (f7_arr[gid]),
    .rs1          (rs1_arr[gid]),
    .rs2          (rs2_arr[gid]),
    .pc           (pc_arr[gid]),
    .alu_result   (alu_result),
    .jump_target  (jump_target),
    .zero         (alu_zero),
    .branch_taken (alu_branch_taken)
  );

  // Buffer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // Buffer next state: fill on accept, empty on drain without accept.
  always_comb begin
    state_next = state;
    if (accept)                       state_next = FULL;
    else if (state == FULL && resp_ready) state_next = EMPTY;
  end

  // Buffer outputs.
  always_comb begin
    resp_valid = (state == FULL);
  end

  // Response payload loads only on accept, so it holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id           <= 1'b0;
      resp_result       <= '0;
      resp_jump_target  <= '0;
      resp_zero         <= 1'b0;
      resp_branch_taken <= 1'b0;
    end else if (accept) begin
      resp_id           <= gid;
      resp_result       <= alu_result;
      resp_jump_target  <= jump_target;
      resp_zero         <= alu_zero;
      resp_branch_taken <= alu_branch_taken;
    end
  end

  // Round-robin history and lock ownership, updated per accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
    end else if (accept) begin
      last_grant <= gid;
      if (req_lock[gid]) begin
        locked     <= 1'b1;
        lock_owner <= gid;
      end else if (locked && lock_owner == gid) begin
        locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_alu_share_arb;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [1:0]    req_lock = 2'b00;
  logic [13:0]   req_opcode;
  logic [5:0]    req_func3;
  logic [13:0]   req_func7;
  logic [2*W-1:0] req_rs1, req_rs2, req_pc;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_id;
  logic [W-1:0]  resp_result, resp_jump_target;
  logic          resp_zero, resp_branch_taken;
  logic          locked, lock_owner;

  logic [6:0]   t_op  [2];
  logic [2:0]   t_f3  [2];
  logic [6:0]   t_f7  [2];
  logic [W-1:0] t_a   [2];
  logic [W-1:0] t_b   [2];
  logic [W-1:0] t_pc  [2];

  assign req_opcode = {t_op[1], t_op[0]};
  assign req_func3  = {t_f3[1], t_f3[0]};
  assign req_func7  = {t_f7[1], t_f7[0]};
  assign req_rs1    = {t_a[1], t_a[0]};
  assign req_rs2    = {t_b[1], t_b[0]};
  assign req_pc     = {t_pc[1], t_pc[0]};

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req_opcode(req_opcode), .req_func3(req_func3),
    .req_func7(req_func7), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_jump_target(resp_jump_target),
    .resp_zero(resp_zero), .resp_branch_taken(resp_branch_taken),
    .locked(locked), .lock_owner(lock_owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic [W-1:0] jt;
    logic         z;
    logic         bt;
  } resp_t;

  resp_t      m_q[$];
  bit         m_locked = 0;
  bit         m_owner = 0;
  bit         m_last = 1;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [1:0] obs_ready;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference ALU semantics, written directly from the instruction meanings.
  function automatic resp_t model_alu(bit id, bit [6:0] op, bit [2:0] f3, bit [6:0] f7,
                                      bit [W-1:0] a, bit [W-1:0] b, bit [W-1:0] pc);
    resp_t r;
    r.id = id; r.res = 0; r.jt = pc + b; r.bt = 0;
    case (op)
      7'h33, 7'h13: begin
        case (f3)
          3'd0: r.res = (op == 7'h33 && f7 == 7'h20) ? a - b : a + b;
          3'd1: r.res = a << b[4:0];
          3'd2: r.res = ($signed(a) < $signed(b)) ? 1 : 0;
          3'd3: r.res = (a < b) ? 1 : 0;
          3'd4: r.res = a ^ b;
          3'd5: r.res = (f7 == 7'h20) ? W'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
          3'd6: r.res = a | b;
          default: r.res = a & b;
        endcase
      end
      7'h63: begin
        r.res = a - b;
        case (f3)
          3'd0: r.bt = (a == b);
          3'd1: r.bt = (a != b);
          3'd4: r.bt = ($signed(a) < $signed(b));
          3'd5: r.bt = ($signed(a) >= $signed(b));
          3'd6: r.bt = (a < b);
          3'd7: r.bt = (a >= b);
          default: r.bt = 0;
        endcase
      end
      7'h6F: r.res = pc + 4;
      7'h67: begin r.res = pc + 4; r.jt = (a + b) & 32'hFFFF_FFFE; end
      7'h37: r.res = b;
      7'h17: r.res = pc + b;
      default: r.res = 0;
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  task automatic set_op(int i, bit [6:0] op, bit [2:0] f3, bit [6:0] f7,
                        bit [W-1:0] a, bit [W-1:0] b, bit [W-1:0] pc);
    t_op[i] = op; t_f3[i] = f3; t_f7[i] = f7; t_a[i] = a; t_b[i] = b; t_pc[i] = pc;
  endtask

  // Called at a falling edge with inputs already driven: compare, predict, advance.
  task automatic do_cycle();
    logic [1:0] cand, exp_ready;
    bit g;
    resp_t e;
    #1;
    cand = req_valid;
    if (m_locked) cand = cand & (m_owner ? 2'b10 : 2'b01);
    if (cand == 2'b11) exp_ready = m_last ? 2'b01 : 2'b10;
    else               exp_ready = cand;
    if (m_q.size() != 0 && !resp_ready) exp_ready = 2'b00;
    obs_ready = req_ready;
    chk("req_ready", req_ready, exp_ready);
    chk("resp_valid", resp_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      e = m_q[0];
      chk("resp_id", resp_id, e.id);
      chk("resp_result", resp_result, e.res);
      chk("resp_jump_target", resp_jump_target, e.jt);
      chk("resp_zero", resp_zero, e.z);
      chk("resp_branch_taken", resp_branch_taken, e.bt);
    end
    chk("locked", locked, m_locked);
    if (m_locked) chk("lock_owner", lock_owner, m_owner);
    if (m_q.size() != 0 && resp_ready) void'(m_q.pop_front());
    if (exp_ready != 2'b00) begin
      g = exp_ready[1];
      e = model_alu(g, t_op[g], t_f3[g], t_f7[g], t_a[g], t_b[g], t_pc[g]);
      m_q.push_back(e);
      $display("txn t=%0t id=%0d op=%h f3=%0d rs1=%h rs2=%h pc=%h lock=%0d -> res=%h jt=%h",
               $time, g, t_op[g], t_f3[g], t_a[g], t_b[g], t_pc[g], req_lock[g], e.res, e.jt);
      m_last = g;
      if (req_lock[g]) begin
        m_locked = 1; m_owner = g;
      end else if (m_locked && m_owner == g) begin
        m_locked = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_q.delete(); m_locked = 0; m_owner = 0; m_last = 1;
  endtask

  task automatic pick_op(int k, output bit [6:0] op, output bit [2:0] f3, output bit [6:0] f7);
    f7 = 0;
    case (k)
      0:  begin op = 7'h33; f3 = 0; end
      1:  begin op = 7'h33; f3 = 0; f7 = 7'h20; end
      2:  begin op = 7'h33; f3 = 1; end
      3:  begin op = 7'h33; f3 = 2; end
      4:  begin op = 7'h33; f3 = 3; end
      5:  begin op = 7'h33; f3 = 4; end
      6:  begin op = 7'h33; f3 = 5; end
      7:  begin op = 7'h33; f3 = 5; f7 = 7'h20; end
      8:  begin op = 7'h33; f3 = 6; end
      9:  begin op = 7'h33; f3 = 7; end
      10: begin op = 7'h13; f3 = 0; end
      11: begin op = 7'h13; f3 = 5; f7 = 7'h20; end
      12: begin op = 7'h63; f3 = 0; end
      13: begin op = 7'h63; f3 = 1; end
      14: begin op = 7'h63; f3 = 4; end
      15: begin op = 7'h63; f3 = 5; end
      16: begin op = 7'h63; f3 = 6; end
      17: begin op = 7'h63; f3 = 7; end
      18: begin op = 7'h6F; f3 = 0; end
      19: begin op = 7'h67; f3 = 0; end
      20: begin op = 7'h37; f3 = 0; end
      default: begin op = 7'h17; f3 = 0; end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [6:0] op; bit [2:0] f3; bit [6:0] f7;
    bit exp_id;
    for (int i = 0; i < 2; i++) set_op(i, 7'h33, 0, 0, 0, 0, 0);

    // Reset state, with both requesters pushing.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_locked", locked, 1'b0);
    req_valid = 2'b00;
    rst = 1'b0;
    model_reset();

    // Single ADD from requester 0.
    set_op(0, 7'h33, 0, 0, 5, 3, 0);
    req_valid = 2'b01;
    do_cycle();
    chk("add_ready", obs_ready, 2'b01);
    req_valid = 2'b00;
    chk("add_resp_id", resp_id, 1'b0);
    chk("add_result", resp_result, 32'h0000_0008);
    do_cycle();

    // Contention: SUB from 0, XOR from 1; accepts must alternate (last was 0).
    set_op(0, 7'h33, 0, 7'h20, 10, 4, 0);
    set_op(1, 7'h33, 4, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0);
    req_valid = 2'b11;
    exp_id = 1;
    for (int k = 0; k < 6; k++) begin
      do_cycle();
      chk("alt_id", resp_id, exp_id);
      chk("alt_result", resp_result, exp_id ? 32'hFFFF_FFFF : 32'h0000_0006);
      exp_id = !exp_id;
    end

    // Backpressure with a taken BEQ held in the buffer.
    set_op(0, 7'h63, 0, 0, 10, 10, 32'h100);
    req_valid = 2'b01;
    do_cycle();
    resp_ready = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      chk("bp_ready", obs_ready, 2'b00);
      chk("bp_branch_taken", resp_branch_taken, 1'b1);
    end
    resp_ready = 1'b1;
    do_cycle();
    chk("bp_resume_ready", obs_ready, 2'b10);

    // Lock sequence by requester 1 while requester 0 stays valid.
    req_valid = 2'b01;
    do_cycle();
    set_op(1, 7'h33, 0, 0, 1, 2, 0);
    req_valid = 2'b11;
    req_lock = 2'b10;
    do_cycle();
    chk("lock1_ready", obs_ready, 2'b10);
    chk("lock1_locked", locked, 1'b1);
    chk("lock1_owner", lock_owner, 1'b1);
    do_cycle();
    chk("lock2_ready", obs_ready, 2'b10);
    req_lock = 2'b00;
    do_cycle();
    chk("lock3_ready", obs_ready, 2'b10);
    chk("lock3_released", locked, 1'b0);
    do_cycle();
    chk("lock_after_ready", obs_ready, 2'b01);

    // JALR.
    set_op(0, 7'h67, 0, 0, 32'h2000, 8, 32'h1000);
    req_valid = 2'b01;
    do_cycle();
    chk("jalr_result", resp_result, 32'h0000_1004);
    chk("jalr_target", resp_jump_target & 32'hFFFF_FFFE, 32'h0000_2008);

    // Asynchronous reset with a full buffer and an active lock.
    set_op(1, 7'h33, 0, 0, 7, 9, 0);
    req_valid = 2'b10;
    req_lock = 2'b10;
    do_cycle();
    req_valid = 2'b00;
    req_lock = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("arst_resp_valid", resp_valid, 1'b0);
    chk("arst_locked", locked, 1'b0);
    chk("arst_result", resp_result, 0);
    chk("arst_jump_target", resp_jump_target, 0);
    chk("arst_flags", {resp_id, resp_zero, resp_branch_taken, lock_owner}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_op(0, 7'h33, 0, 0, 1, 1, 0);
    req_valid = 2'b11;
    do_cycle();
    chk("arst_first_winner", obs_ready, 2'b01);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        pick_op(int'($urandom_range(0, 21)), op, f3, f7);
        t_op[i] = op; t_f3[i] = f3; t_f7[i] = f7;
        t_a[i]  = $urandom;
        t_b[i]  = ($urandom_range(0, 3) == 0) ? t_a[i] : $urandom;
        t_pc[i] = $urandom & 32'hFFFF_FFFC;
      end
      req_valid  = 2'($urandom_range(0, 3));
      req_lock   = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      resp_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
